// File: rtl/uart_tx_flow.sv
// UART transmitter: TX FIFO, 16x phase-accumulator baud tick, RTS/CTS throttling, 8N1/8N2 frames.
// Optional parity stage (8E/8O framing) is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_flow #(
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                            clk_sys,
  input  logic                            reset,
  input  logic [15:0]                     baud_increment,
  input  logic [7:0]                      wr_data,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic                            flow_en,
  input  logic                            cts_n,
  output logic                            txd,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [2:0]                      dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic LAST_STOP = (STOP_BITS == 2);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_tx_flow: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       acc_q;
  logic [16:0]       acc_sum;
  logic              tick;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic              stop_q, stop_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              cts_s1_q, cts_s2_q;
  logic              cts_ok;
  logic              bit_end;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     count_q, count_d;
  logic              fifo_full, fifo_empty;
  logic              push, pop;

  // Write handshake: a byte is taken on any cycle where wr_valid and wr_ready
  // are both high; wr_ready depends only on FIFO occupancy, never on wr_valid.
  assign fifo_full  = (count_q == LW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign wr_ready   = ~fifo_full;
  assign push       = wr_valid & ~fifo_full;

  // Tick is the carry out of the accumulator add; it free-runs in every state.
  assign acc_sum = {1'b0, acc_q} + {1'b0, baud_increment};
  assign tick    = acc_sum[16];
  assign bit_end = tick && (cnt_q == 4'd15);
  assign cts_ok  = ~flow_en | ~cts_s2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q != S_IDLE && tick) begin
      cnt_d = cnt_q + 4'd1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty && cts_ok) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          cnt_d   = 4'd0;
          state_d = S_START;
`ifdef UART_TX_PARITY_EN
          parity_d = (^mem[rd_ptr_q]) ^ (PARITY_ODD != 0);
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          stop_d  = 1'b0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (stop_q == LAST_STOP) begin
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The line level is registered from the current state, so it lags the FSM by one clock.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      S_IDLE:   txd_d = 1'b1;
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = parity_q;
`endif
      S_STOP:   txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= 16'd0;
      cnt_q    <= 4'd0;
      bit_q    <= 3'd0;
      stop_q   <= 1'b0;
      shift_q  <= 8'd0;
      txd_q    <= 1'b1;
      cts_s1_q <= 1'b1;
      cts_s2_q <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_sum[15:0];
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      cts_s1_q <= cts_n;
      cts_s2_q <= cts_s1_q;
      count_q  <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign txd        = txd_q;
  assign busy       = (state_q != S_IDLE) | (count_q != '0);
  assign fifo_level = count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_tx_flow.sv
// Bench for uart_tx_flow: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed timing and level expectations.
module tb_uart_tx_flow;
  localparam int DEPTH = 16;
  localparam int STOP  = 1;
  localparam int P_ODD = 0;
  localparam int LW    = 5;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   baud_increment = 16'd0;
  logic [7:0]    wr_data = 8'd0;
  logic          wr_valid = 1'b0;
  logic          flow_en = 1'b0;
  logic          cts_n = 1'b1;
  logic          wr_ready, txd, busy;
  logic [LW-1:0] fifo_level;
  logic [2:0]    dbg_state;

  uart_tx_flow #(.FIFO_DEPTH(DEPTH), .STOP_BITS(STOP), .PARITY_ODD(P_ODD)) dut (
    .clk_sys(clk_sys), .reset(reset), .baud_increment(baud_increment),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .flow_en(flow_en), .cts_n(cts_n), .txd(txd), .busy(busy),
    .fifo_level(fifo_level), .dbg_state(dbg_state)
  );

  // clock / reset
  always #10 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Reference model: a line frame is a list of levels, each held for 16 baud ticks.
  logic [7:0]  m_fifo[$];
  logic        m_bits[$];
  logic [15:0] m_acc = 16'd0;
  logic        m_sync1 = 1'b1, m_sync2 = 1'b1;
  logic        m_active = 1'b0;
  int          m_ticks = 0;
  logic        m_txd = 1'b1;
  bit          cmp_en = 1'b0;

  always @(posedge clk_sys) begin
    logic [16:0] sum;
    logic        cts_ok;
    logic [7:0]  b;
    int          size_before;
    if (reset) begin
      m_acc = 16'd0; m_sync1 = 1'b1; m_sync2 = 1'b1;
      m_active = 1'b0; m_ticks = 0; m_txd = 1'b1;
      m_fifo.delete();
    end else begin
      sum = {1'b0, m_acc} + {1'b0, baud_increment};
      cts_ok = !flow_en || !m_sync2;
      m_txd = m_active ? m_bits[m_ticks / 16] : 1'b1;
      size_before = m_fifo.size();
      if (!m_active) begin
        if (size_before != 0 && cts_ok) begin
          b = m_fifo.pop_front();
          m_bits.delete();
          m_bits.push_back(1'b0);
          for (int i = 0; i < 8; i++) m_bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
          m_bits.push_back((^b) ^ (P_ODD != 0));
`endif
          for (int i = 0; i < STOP; i++) m_bits.push_back(1'b1);
          m_active = 1'b1;
          m_ticks = 0;
        end
      end else if (sum[16]) begin
        m_ticks++;
        if (m_ticks == 16 * m_bits.size()) m_active = 1'b0;
      end
      if (wr_valid && size_before < DEPTH) m_fifo.push_back(wr_data);
      m_acc = sum[15:0];
      m_sync2 = m_sync1;
      m_sync1 = cts_n;
    end
    cmp_en = 1'b1;
  end

  // scoreboard compare, every cycle, away from the active edge
  always @(posedge clk_sys) begin
    #1;
    if (cmp_en) begin
      check("model_txd", txd, m_txd);
      check("model_busy", busy, m_active || m_fifo.size() != 0);
      check("model_level", fifo_level, m_fifo.size());
      check("model_wr_ready", wr_ready, m_fifo.size() != DEPTH);
    end
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_data = d;
    wr_valid = 1'b1;
    @(negedge clk_sys);
    wr_valid = 1'b0;
  endtask

  task automatic wait_txd(input string name, input logic lvl, input int max, output int n);
    n = 0;
    while (txd !== lvl && n < max) begin
      @(negedge clk_sys);
      n++;
    end
    check(name, txd, lvl);
  endtask

  task automatic run_len(output int n);
    logic l;
    l = txd;
    n = 0;
    while (txd === l && n < 20000) begin
      @(negedge clk_sys);
      n++;
    end
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max) begin
      @(negedge clk_sys);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  initial begin
    int n;
    logic exp_par;
    wait_clk(3);
    reset = 1'b0;
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_level", fifo_level, 0);
    check("rst_wr_ready", wr_ready, 1'b1);

    // single 0x55 frame at 2416: 16 ticks of 65536/2416 clk = 434 clk per bit
    baud_increment = 16'd2416;
    wait_clk(5);
    write_byte(8'h55);
    check("t1_busy_after_write", busy, 1'b1);
    check("t1_txd_lat1", txd, 1'b1);
    wait_clk(1);
    check("t1_txd_lat2", txd, 1'b1);
    wait_clk(1);
    check("t1_start_at_2clk", txd, 1'b0);
    for (int i = 0; i < 9; i++) begin
      run_len(n);
      check_range($sformatf("t1_bit%0d_len", i), n, 406, 462);
    end
    check("t1_stop_level", txd, 1'b1);
    check("t1_busy_in_stop", busy, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    check_range("t1_stop_len", n, 406, 462);

    // CTS held off: FIFO fills to 16, 17th byte dropped
    baud_increment = 16'd16384;
    flow_en = 1'b1;
    cts_n = 1'b1;
    wait_clk(3);
    wr_valid = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      wr_data = 8'(i);
      @(negedge clk_sys);
    end
    wr_valid = 1'b0;
    check("t2_level_full", fifo_level, 16);
    check("t2_wr_ready_low", wr_ready, 1'b0);
    wait_clk(20);
    check("t2_txd_held", txd, 1'b1);
    check("t2_level_held", fifo_level, 16);

    // release CTS, then pull it back during the fourth frame
    cts_n = 1'b0;
    wait_txd("t3_start_seen", 1'b0, 20, n);
    check_range("t3_cts_latency", n, 1, 7);
    n = 0;
    while (fifo_level !== 12 && n < 4000) begin
      @(negedge clk_sys);
      n++;
    end
    check("t3_level_12", fifo_level, 12);
    wait_clk(200);
    cts_n = 1'b1;
    wait_clk(1000);
    check("t3_held_level", fifo_level, 12);
    check("t3_held_txd", txd, 1'b1);
    check("t3_held_busy", busy, 1'b1);
    cts_n = 1'b0;
    wait_idle("t3_drain", 12 * 700);
    check("t3_drained_level", fifo_level, 0);
    flow_en = 1'b0;

    // reset in the middle of D4 of 0x3C with more bytes queued
    write_byte(8'h3C);
    write_byte(8'h11);
    write_byte(8'h22);
    wait_txd("t4_start_seen", 1'b0, 20, n);
    wait_clk(5 * 64 + 32);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    check("t4_txd_after_rst", txd, 1'b1);
    check("t4_level_after_rst", fifo_level, 0);
    check("t4_busy_after_rst", busy, 1'b0);
    write_byte(8'hA3);
    wait_txd("t4_a3_start", 1'b0, 20, n);
    // 0xA3 bit D2 is 0; freeze the baud generator there
    wait_clk(220);
    check("t4_a3_d2", txd, 1'b0);
    baud_increment = 16'd0;
    wait_clk(100);
    check("t4_frozen_txd", txd, 1'b0);
    check("t4_frozen_busy", busy, 1'b1);
    baud_increment = 16'd16384;
    wait_idle("t4_a3_done", 2000);

    // 0x07: D7 = 0, then parity (or stop) bit
    write_byte(8'h07);
    wait_txd("t5_start", 1'b0, 20, n);
    wait_clk(8 * 64 + 32);
    check("t5_d7", txd, 1'b0);
    wait_clk(64);
`ifdef UART_TX_PARITY_EN
    exp_par = 1'b1 ^ (P_ODD != 0);
`else
    exp_par = 1'b1;
`endif
    check("t5_bit_after_d7", txd, exp_par);
    wait_idle("t5_done", 2000);

    // slow baud 201 (5217 clk/bit), then switch to 2416 mid-frame
    baud_increment = 16'd201;
    write_byte(8'h55);
    wait_txd("t6_start", 1'b0, 20, n);
    run_len(n);
    check_range("t6_start_len", n, 4891, 5543);
    run_len(n);
    check_range("t6_d0_len", n, 4891, 5543);
    wait_clk(100);
    baud_increment = 16'd2416;
    run_len(n);
    run_len(n);
    check_range("t6_d2_len_fast", n, 406, 462);
    wait_idle("t6_done", 6000);

    wait_clk(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(90000 * 20);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
